// File: rtl/i2c_reg_bridge_pkg.sv
// i2c_pkg: shared constants for the I2C slave to register-bank bridge.
package i2c_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_ACKA    = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_ACKD    = 3'd4;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic [7:0] RD_ERR_DATA_DEF = 8'hFF;
endpackage

// File: rtl/i2c_reg_bridge_sync2.sv
// sync2: 1-bit two-flop synchronizer with synchronous reset.
module sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);
    logic meta;
    always_ff @(posedge CLK) begin
        meta <= RST ? 1'b0 : D;
        Q    <= RST ? 1'b0 : meta;
    end
endmodule

// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: turns I2C slave address/data handshakes into register-bank
// write strobes and timed-out read requests, releasing the SCL stall via acks.
module i2c_reg_bridge #(
    parameter int         TIMEOUT     = 64,
    parameter logic [7:0] RD_ERR_DATA = i2c_pkg::RD_ERR_DATA_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] S_ADDR,
    input  logic       S_RW,
    input  logic       S_ARDY,
    input  logic [7:0] S_ODATA,
    input  logic       S_DRDY,
    output logic [7:0] S_IDATA,
    output logic       S_ACKA_RDY,
    output logic       S_ACKD_RDY,
    output logic [6:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WE,
    output logic       REG_RE,
    input  logic [7:0] REG_RDATA,
    input  logic       REG_RVALID,
    output logic       ERR,
    input  logic       ERR_CLR
);
    import i2c_pkg::*;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    logic a_s, d_s, a_q, d_q, a_rise, d_rise, rw, tmo;
    logic [2:0] state;
    logic [TW-1:0] tcnt;
    sync2 u_sync_a (.CLK(CLK), .RST(RST), .D(S_ARDY), .Q(a_s));
    sync2 u_sync_d (.CLK(CLK), .RST(RST), .D(S_DRDY), .Q(d_s));
    assign a_rise = a_s & ~a_q;
    assign d_rise = d_s & ~d_q;
    // An abort (ARDY low) outranks a timeout landing in the same cycle.
    assign tmo = (state == ST_RD_WAIT) && a_s && !REG_RVALID && (tcnt == T_LAST);
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q        <= 1'b0;
            d_q        <= 1'b0;
            state      <= ST_IDLE;
            tcnt       <= '0;
            rw         <= RW_WRITE;
            S_IDATA    <= '0;
            REG_ADDR   <= '0;
            REG_WDATA  <= '0;
            S_ACKA_RDY <= 1'b0;
            S_ACKD_RDY <= 1'b0;
            REG_WE     <= 1'b0;
            REG_RE     <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            a_q    <= a_s;
            d_q    <= d_s;
            REG_WE <= 1'b0;
            REG_RE <= 1'b0;
            ERR    <= tmo | (ERR & ~ERR_CLR);
            tcnt   <= (tcnt == T_MAX) ? tcnt : tcnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (a_rise) begin
                        REG_ADDR <= S_ADDR;
                        rw       <= S_RW;
                        tcnt     <= '0;
                        if (S_RW == RW_READ) begin
                            REG_RE <= 1'b1;
                            state  <= ST_RD_WAIT;
                        end else begin
                            S_ACKA_RDY <= 1'b1;
                            state      <= ST_ACKA;
                        end
                    end else if (d_rise) begin
                        S_ACKD_RDY <= 1'b1;
                        state      <= ST_ACKD;
                        if (rw == RW_WRITE) begin
                            REG_WDATA <= S_ODATA;
                            REG_WE    <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (!a_s) begin
                        state <= ST_IDLE;
                    end else if (REG_RVALID || tmo) begin
                        S_IDATA    <= REG_RVALID ? REG_RDATA : RD_ERR_DATA;
                        S_ACKA_RDY <= 1'b1;
                        state      <= ST_ACKA;
                    end
                end
                ST_ACKA: begin
                    if (!a_s) begin
                        S_ACKA_RDY <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_ACKD: begin
                    if (!d_s) begin
                        S_ACKD_RDY <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge: directed checks of write, read, timeout, abort, reset and
// simultaneous-edge behaviour of i2c_reg_bridge.
module tb_i2c_reg_bridge;
    localparam int TIMEOUT = 8;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] S_ADDR = '0;
    logic       S_RW = 1'b0;
    logic       S_ARDY = 1'b0;
    logic [7:0] S_ODATA = '0;
    logic       S_DRDY = 1'b0;
    logic [7:0] S_IDATA;
    logic       S_ACKA_RDY, S_ACKD_RDY;
    logic [6:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE, REG_RE;
    logic [7:0] REG_RDATA = '0;
    logic       REG_RVALID = 1'b0;
    logic       ERR;
    logic       ERR_CLR = 1'b0;
    int passed = 0;
    int total = 0;
    int we_cnt = 0;
    int both_cnt = 0;

    i2c_reg_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .S_ADDR(S_ADDR), .S_RW(S_RW), .S_ARDY(S_ARDY),
        .S_ODATA(S_ODATA), .S_DRDY(S_DRDY), .S_IDATA(S_IDATA),
        .S_ACKA_RDY(S_ACKA_RDY), .S_ACKD_RDY(S_ACKD_RDY), .REG_ADDR(REG_ADDR),
        .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE),
        .REG_RDATA(REG_RDATA), .REG_RVALID(REG_RVALID), .ERR(ERR), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RST && REG_WE) we_cnt++;
        if (REG_WE && REG_RE) both_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        tick(2);
        chk("rst_acka", S_ACKA_RDY, 0);
        chk("rst_ackd", S_ACKD_RDY, 0);
        chk("rst_we", REG_WE, 0);
        chk("rst_re", REG_RE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_idata", S_IDATA, 0);
        chk("rst_addr", REG_ADDR, 0);
        chk("rst_wdata", REG_WDATA, 0);
        RST = 1'b0;
        tick(2);

        // write: address phase then data phase
        S_ADDR = 7'h15; S_RW = 1'b0; S_ARDY = 1'b1;
        tick(2);
        chk("wr_acka_early", S_ACKA_RDY, 0);
        tick();
        chk("wr_acka", S_ACKA_RDY, 1);
        chk("wr_addr", REG_ADDR, 7'h15);
        chk("wr_no_re", REG_RE, 0);
        S_ARDY = 1'b0;
        tick(2);
        chk("wr_acka_hold", S_ACKA_RDY, 1);
        tick();
        chk("wr_acka_rel", S_ACKA_RDY, 0);
        S_ODATA = 8'hA5; S_DRDY = 1'b1;
        tick(3);
        chk("wr_we", REG_WE, 1);
        chk("wr_wdata", REG_WDATA, 8'hA5);
        chk("wr_ackd", S_ACKD_RDY, 1);
        tick();
        chk("wr_we_pulse", REG_WE, 0);
        chk("wr_ackd_hold", S_ACKD_RDY, 1);
        S_DRDY = 1'b0;
        tick(3);
        chk("wr_ackd_rel", S_ACKD_RDY, 0);
        chk("wr_we_cnt", we_cnt, 1);

        // read with REG_RVALID four cycles after REG_RE
        S_ADDR = 7'h03; S_RW = 1'b1; S_ARDY = 1'b1;
        tick(3);
        chk("rd_re", REG_RE, 1);
        chk("rd_addr", REG_ADDR, 7'h03);
        tick();
        chk("rd_re_pulse", REG_RE, 0);
        tick(3);
        chk("rd_acka_wait", S_ACKA_RDY, 0);
        REG_RDATA = 8'h3C; REG_RVALID = 1'b1;
        tick();
        REG_RVALID = 1'b0; REG_RDATA = 8'h00;
        chk("rd_idata", S_IDATA, 8'h3C);
        chk("rd_acka", S_ACKA_RDY, 1);
        chk("rd_err", ERR, 0);
        S_ARDY = 1'b0;
        tick(3);
        chk("rd_acka_rel", S_ACKA_RDY, 0);
        // data phase of a read: ack only, no register access
        S_DRDY = 1'b1;
        tick(3);
        chk("rd_ackd", S_ACKD_RDY, 1);
        chk("rd_no_we", REG_WE, 0);
        S_DRDY = 1'b0;
        tick(3);
        chk("rd_ackd_rel", S_ACKD_RDY, 0);

        // read timeout
        S_ADDR = 7'h05; S_RW = 1'b1; S_ARDY = 1'b1;
        tick(3);
        chk("to_re", REG_RE, 1);
        tick(TIMEOUT - 1);
        chk("to_acka_early", S_ACKA_RDY, 0);
        chk("to_err_early", ERR, 0);
        tick();
        chk("to_acka", S_ACKA_RDY, 1);
        chk("to_idata", S_IDATA, 8'hFF);
        chk("to_err", ERR, 1);
        S_ARDY = 1'b0;
        tick(3);
        chk("to_acka_rel", S_ACKA_RDY, 0);
        chk("to_err_sticky", ERR, 1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("to_err_clr", ERR, 0);

        // abort during RD_WAIT, then a normal write
        S_ADDR = 7'h07; S_RW = 1'b1; S_ARDY = 1'b1;
        tick(3);
        chk("ab_re", REG_RE, 1);
        S_ARDY = 1'b0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            tick();
            chk("ab_no_acka", S_ACKA_RDY, 0);
        end
        chk("ab_err", ERR, 0);
        S_ADDR = 7'h09; S_RW = 1'b0; S_ARDY = 1'b1;
        tick(3);
        chk("ab_wr_acka", S_ACKA_RDY, 1);
        chk("ab_wr_addr", REG_ADDR, 7'h09);
        S_ARDY = 1'b0;
        tick(3);
        S_ODATA = 8'h5A; S_DRDY = 1'b1;
        tick(3);
        chk("ab_wr_we", REG_WE, 1);
        chk("ab_wr_wdata", REG_WDATA, 8'h5A);
        S_DRDY = 1'b0;
        tick(3);
        chk("ab_wr_ackd_rel", S_ACKD_RDY, 0);

        // reset while in ACKA
        S_ADDR = 7'h0B; S_RW = 1'b0; S_ARDY = 1'b1;
        tick(3);
        chk("rs_acka_pre", S_ACKA_RDY, 1);
        RST = 1'b1;
        tick();
        chk("rs_acka", S_ACKA_RDY, 0);
        chk("rs_ackd", S_ACKD_RDY, 0);
        chk("rs_addr", REG_ADDR, 0);
        chk("rs_wdata", REG_WDATA, 0);
        chk("rs_idata", S_IDATA, 0);
        chk("rs_we_re_err", {REG_WE, REG_RE, ERR}, 0);
        S_ARDY = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(2);

        // simultaneous ARDY and DRDY rise: address path only
        S_ADDR = 7'h14; S_RW = 1'b0; S_ODATA = 8'h77; S_ARDY = 1'b1; S_DRDY = 1'b1;
        tick(3);
        chk("sim_acka", S_ACKA_RDY, 1);
        chk("sim_ackd", S_ACKD_RDY, 0);
        chk("sim_we", REG_WE, 0);
        S_ARDY = 1'b0;
        tick(3);
        chk("sim_acka_rel", S_ACKA_RDY, 0);
        tick(3);
        chk("sim_no_ackd", S_ACKD_RDY, 0);
        S_DRDY = 1'b0;
        tick(3);
        chk("sim_wdata_kept", REG_WDATA, 0);

        chk("we_total", we_cnt, 2);
        chk("we_re_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_reg_bridge.md
I2C_REG_BRIDGE -- requirements
Module: i2c_reg_bridge

Interface
REQ-001 Parameter TIMEOUT, 64, clock cycles to wait for REG_RVALID before a read is aborted.
REQ-002 Parameter RD_ERR_DATA, 8'hFF, byte returned to the bus on read timeout.
REQ-003 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 S_ADDR  in  7  register address from the I2C slave.
REQ-006 S_RW  in  1  transfer direction from the I2C slave: 0 = write, 1 = read.
REQ-007 S_ARDY  in  1  address phase complete; asynchronous to CLK.
REQ-008 S_ODATA  in  8  write byte from the I2C slave.
REQ-009 S_DRDY  in  1  data phase complete; asynchronous to CLK.
REQ-010 S_IDATA  out  8  read byte driven to the I2C slave.
REQ-011 S_ACKA_RDY  out  1  releases the slave's SCL stall at the address ACK.
REQ-012 S_ACKD_RDY  out  1  releases the slave's SCL stall at the data ACK.
REQ-013 REG_ADDR  out  7  register-bank address.
REQ-014 REG_WDATA  out  8  register-bank write data.
REQ-015 REG_WE  out  1  one-cycle write strobe.
REQ-016 REG_RE  out  1  one-cycle read request.
REQ-017 REG_RDATA  in  8  read data, valid while REG_RVALID is high.
REQ-018 REG_RVALID  in  1  read-data valid; arrives 1..N cycles after REG_RE.
REQ-019 ERR  out  1  sticky read-timeout flag.
REQ-020 ERR_CLR  in  1  clears ERR.

Function
REQ-021 S_ARDY and S_DRDY SHALL each pass through a 2-FF synchronizer; a rising edge is detected on the cycle the second FF goes 1.
REQ-022 On a detected S_ARDY rise, S_ADDR and S_RW SHALL be captured into REG_ADDR and an internal rw flag; the slave holds SCL, so these inputs are stable.
REQ-023 FSM states: IDLE, RD_WAIT, ACKA, WR, ACKD.
REQ-024 IDLE plus ARDY rise with rw=1: assert REG_RE for exactly 1 cycle (the cycle after detection), then go to RD_WAIT.
REQ-025 IDLE plus ARDY rise with rw=0: go directly to ACKA.
REQ-026 RD_WAIT: on REG_RVALID, latch REG_RDATA into S_IDATA and go to ACKA.
REQ-027 RD_WAIT timeout: if TIMEOUT cycles elapse without REG_RVALID, load RD_ERR_DATA into S_IDATA, set ERR and go to ACKA.
REQ-028 RD_WAIT abort: if the synchronized ARDY falls, return to IDLE with no ack.
REQ-029 ACKA: hold S_ACKA_RDY=1 until the synchronized ARDY is 0, then clear it and return to IDLE.
REQ-030 IDLE plus DRDY rise with rw=0: capture S_ODATA into REG_WDATA, pulse REG_WE for 1 cycle (the cycle after detection), then go to ACKD.
REQ-031 IDLE plus DRDY rise with rw=1: go directly to ACKD with no register access.
REQ-032 ACKD: hold S_ACKD_RDY=1 until the synchronized DRDY is 0, then clear it and return to IDLE.
REQ-033 If ARDY and DRDY rises are detected in the same cycle, ARDY SHALL win; the DRDY edge is dropped.
REQ-034 Edges arriving outside IDLE SHALL be ignored.
REQ-035 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, cleared on entry to RD_WAIT, and SHALL saturate rather than wrap.
REQ-036 ERR_CLR SHALL clear ERR; if ERR_CLR and a new timeout occur in the same cycle, set wins.
REQ-037 REG_WE and REG_RE SHALL never be high in the same cycle.

Reset
REQ-038 RST SHALL take priority over all other inputs.
REQ-039 On RST: FSM to IDLE, synchronizers to 0, timeout counter to 0; S_IDATA, REG_ADDR and REG_WDATA to 0; S_ACKA_RDY, S_ACKD_RDY, REG_WE, REG_RE and ERR to 0.
REQ-040 A reset asserted mid-transfer SHALL drop any pending ack; the slave remains stalled until its own reset or a new handshake.

Structure
REQ-041 A shared package i2c_pkg SHALL hold the FSM state encoding, RW_WRITE=0 / RW_READ=1, and the default RD_ERR_DATA.
REQ-042 One sub-module, sync2 (a 1-bit 2-FF synchronizer with synchronous reset), SHALL be instantiated twice.

Verification
REQ-043 Write: S_ADDR=7'h15, S_RW=0, ARDY pulse, then S_ODATA=8'hA5 with DRDY -> one REG_WE with REG_ADDR=7'h15, REG_WDATA=8'hA5; S_ACKA_RDY then S_ACKD_RDY each assert and release after their strobe falls.
REQ-044 Read: S_ADDR=7'h03, S_RW=1, REG_RVALID 4 cycles after REG_RE with REG_RDATA=8'h3C -> S_IDATA=8'h3C before S_ACKA_RDY=1; ERR stays 0.
REQ-045 Timeout: read with REG_RVALID never asserted -> S_ACKA_RDY rises exactly TIMEOUT cycles after REG_RE; S_IDATA=8'hFF; ERR=1. ERR_CLR pulse -> ERR=0.
REQ-046 Abort: ARDY dropped during RD_WAIT -> FSM returns to IDLE with S_ACKA_RDY never asserted; the next write completes normally.
REQ-047 Reset: RST asserted while in ACKA -> next cycle all outputs are 0 and FSM is IDLE.
REQ-048 Simultaneous events: ARDY and DRDY rise in the same cycle -> address path only; no REG_WE.
